wordle_guess_scorer: RTL and testbench
======================================

// Module: wordle_guess_scorer
// PURPOSE
//  Downstream consumer of the on-screen keyboard's selected key.
//  - Assembles the key presses into a WORD_LEN-letter guess, with delete and enter.
//  - Scores each entered guess against a latched target word (green/yellow/grey, duplicate-aware).
//  - Counts guesses and drives done/win/lose; done feeds the keyboard's done input.
// PARAMETERS
//  WORD_LEN     5   letters per guess
//  MAX_GUESSES  6   guesses allowed per game
//  KEY_DEL      26  key code for delete (keyboard ',')
//  KEY_ENT      27  key code for enter (keyboard '.')
// PORTS
//  Clk          in   1            system clock; single clock domain
//  reset        in   1            synchronous, active-high
//  sel          in   1            one-cycle pulse: key is pressed
//  key          in   5            key code: 0..25 = A..Z, 26 = DEL, 27 = ENT, 28..31 ignored
//  target       in   5*WORD_LEN   target word, letter i at [5i+4:5i]; sampled at reset and at Ack
//  Ack          in   1            acknowledge game over; starts a new game
//  guess        out  5*WORD_LEN   current guess buffer (same packing as target)
//  guess_len    out  3            letters entered in current guess
//  guess_num    out  3            completed guesses
//  score        out  2*WORD_LEN   per-letter score, [2i+1:2i]: 00 grey, 01 yellow, 10 green
//  score_valid  out  1            one-cycle pulse: score holds the result of the last guess
//  busy         out  1            scoring in progress; sel ignored
//  win, lose    out  1            game result; held until Ack
//  done         out  1            high in DONE state
// BEHAVIOUR
//  - Reset (sync): state ENTRY; guess, guess_len, guess_num, score = 0; all flags 0; target latched.
//  - States: ENTRY, GREEN, YELLOW, REPORT, DONE.
//  - ENTRY, on sel, by key:
//    - Letter (0..25) with len<WORD_LEN: write slot len, len+1. If len==WORD_LEN: ignored.
//    - DEL with len>0: len-1, slot zeroed. If len==0: ignored.
//    - ENT with len==WORD_LEN: go to GREEN, busy=1. Otherwise: ignored.
//    - Codes 28..31: ignored.
//  - GREEN: exactly WORD_LEN cycles, index i=0..4.
//    - guess[i]==target[i]: score[i]=green, used_t[i]=1, done_g[i]=1.
//    - Otherwise score[i]=grey.
//  - YELLOW: exactly WORD_LEN*WORD_LEN cycles, outer i, inner j=0..4, one compare per cycle.
//    - Match if !done_g[i] && !used_t[j] && guess[i]==target[j].
//    - First match per i: score[i]=yellow, used_t[j]=1, done_g[i]=1.
//    - Remaining j for that i: no effect.
//  - Fixed latency: ENT accepted at cycle 0 -> score_valid at cycle 31 (REPORT state).
//  - REPORT (1 cycle): score_valid=1, guess_num+1.
//    - All green: win=1 -> DONE.
//    - Else if new guess_num==MAX_GUESSES: lose=1 -> DONE.
//    - Else: clear guess and len, clear used_t/done_g -> ENTRY.
//    - score holds until the next GREEN.
//  - DONE: done=1; sel ignored. Ack -> re-latch target, clear all counters, flags and score -> ENTRY.
//  - Ack in any other state: ignored. Ack and sel in the same cycle in DONE: Ack wins, sel dropped.
//  - sel during GREEN, YELLOW or REPORT: dropped, not queued.
//  - reset mid-scoring: immediate return to reset values; no score_valid.
//  - Widths: guess_len and guess_num saturate logically at WORD_LEN and MAX_GUESSES; no wrap possible.
// STRUCTURE
//  - Shared package/include: KEY_DEL, KEY_ENT, score codes (SC_GREY, SC_YEL, SC_GRN), one-hot state encodings.
//  - One natural sub-module: wordle_letter_cmp, a registered 5-bit compare plus used/done mask check
//    (used by both GREEN and YELLOW). Everything else stays inline.
// TESTING
//  1. target "CRANE"; type C,R,A,N,E,ENT -> score_valid at cycle 31, score=10'b10_10_10_10_10, win=1, done=1.
//  2. target "APPLE"; guess "PAPAL" -> score=10'b01_00_10_01_01 (Y,Y,G,grey,Y pos0..4), guess_num=1, back to ENTRY.
//  3. Entry edges:
//     - DEL at len 0 -> len stays 0.
//     - 6 letters -> len=5, slot4 holds the 5th letter.
//     - ENT at len 4 -> no busy.
//     - key 30 -> ignored.
//  4. Six wrong guesses against "CRANE" -> lose=1, done=1 after the 6th score_valid; sel ignored.
//     Ack -> guess_num=0, flags 0, new target latched.
//  5. reset asserted mid-YELLOW -> next cycle all outputs at reset values; no score_valid afterwards.
//  6. sel+ENT pulses during busy and Ack outside DONE -> no state change.

Source files
------------

// File: rtl/wordle_guess_scorer_pkg.sv
// Shared types and constants for the Wordle guess scorer.
// Letters are 5-bit codes 0..25 (A..Z); a word packs letter i at [5i+4:5i].
package wordle_guess_scorer_pkg;

    localparam int WORD_LEN    = 5;
    localparam int MAX_GUESSES = 6;

    typedef logic [4:0]                letter_t;
    typedef logic [WORD_LEN-1:0][4:0]  word_t;
    typedef logic [1:0]                score_t;
    typedef logic [WORD_LEN-1:0][1:0]  score_vec_t;
    typedef logic [2:0]                cnt_t;

    localparam letter_t KEY_LAST_LETTER = 5'd25;
    localparam letter_t KEY_DEL         = 5'd26;
    localparam letter_t KEY_ENT         = 5'd27;

    localparam score_t SC_GREY = 2'b00;
    localparam score_t SC_YEL  = 2'b01;
    localparam score_t SC_GRN  = 2'b10;

    localparam cnt_t LEN_FULL = 3'(WORD_LEN);
    localparam cnt_t IDX_LAST = 3'(WORD_LEN - 1);
    localparam cnt_t NUM_MAX  = 3'(MAX_GUESSES);

    typedef enum logic [4:0] {
        ST_ENTRY  = 5'b00001,
        ST_GREEN  = 5'b00010,
        ST_YELLOW = 5'b00100,
        ST_REPORT = 5'b01000,
        ST_DONE   = 5'b10000
    } state_e;

endpackage

// File: rtl/wordle_guess_scorer_if.sv
// Key/target inputs and guess/score/status outputs of the scorer.
interface wordle_guess_scorer_if;
    import wordle_guess_scorer_pkg::*;

    logic       sel;
    letter_t    key;
    word_t      target;
    logic       Ack;
    word_t      guess;
    cnt_t       guess_len;
    cnt_t       guess_num;
    score_vec_t score;
    logic       score_valid;
    logic       busy;
    logic       win;
    logic       lose;
    logic       done;

    modport master (
        output sel, key, target, Ack,
        input  guess, guess_len, guess_num, score, score_valid, busy, win, lose, done
    );

    modport slave (
        input  sel, key, target, Ack,
        output guess, guess_len, guess_num, score, score_valid, busy, win, lose, done
    );

endinterface

// File: rtl/wordle_guess_scorer_letter_cmp.sv
// Registered letter equality; the used/done mask is applied on the registered
// result so mask updates from the previous compare are always seen.
module wordle_letter_cmp
    import wordle_guess_scorer_pkg::*;
(
    input  logic    Clk,
    input  logic    reset,
    input  letter_t a_i,
    input  letter_t b_i,
    input  logic    used_i,
    input  logic    done_i,
    output logic    hit_o
);

    logic eq_q;

    always_ff @(posedge Clk) begin
        if (reset) eq_q <= 1'b0;
        else       eq_q <= (a_i == b_i);
    end

    assign hit_o = eq_q && !used_i && !done_i;

endmodule

// File: rtl/wordle_guess_scorer.sv
// Guess entry, duplicate-aware green/yellow scoring against a latched target,
// and game win/lose tracking.
module wordle_guess_scorer
    import wordle_guess_scorer_pkg::*;
(
    input  logic                  Clk,
    input  logic                  reset,
    wordle_guess_scorer_if.slave  bus
);

    state_e               state_q, state_d;
    word_t                guess_q, guess_d;
    word_t                tgt_q, tgt_d;
    score_vec_t           score_q, score_d;
    cnt_t                 len_q, len_d;
    cnt_t                 num_q, num_d;
    cnt_t                 i_q, i_d;
    cnt_t                 j_q, j_d;
    logic [WORD_LEN-1:0]  used_q, used_d;
    logic [WORD_LEN-1:0]  doneg_q, doneg_d;
    logic                 win_q, win_d;
    logic                 lose_q, lose_d;

    logic    hit, all_grn, cmp_used, cmp_done;
    letter_t cmp_a, cmp_b;

    // Comparator is loaded with the pair for the next cycle, so its registered
    // result lines up with (i_q, j_q) while that pair is being applied.
    assign cmp_a    = guess_q[i_d];
    assign cmp_b    = tgt_q[j_d];
    assign cmp_used = (state_q == ST_YELLOW) && used_q[j_q];
    assign cmp_done = (state_q == ST_YELLOW) && doneg_q[i_q];

    wordle_letter_cmp u_cmp (
        .Clk    (Clk),
        .reset  (reset),
        .a_i    (cmp_a),
        .b_i    (cmp_b),
        .used_i (cmp_used),
        .done_i (cmp_done),
        .hit_o  (hit)
    );

    always_comb begin
        all_grn = 1'b1;
        for (int k = 0; k < WORD_LEN; k++)
            if (score_q[k] != SC_GRN) all_grn = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        guess_d = guess_q;
        tgt_d   = tgt_q;
        score_d = score_q;
        len_d   = len_q;
        num_d   = num_q;
        used_d  = used_q;
        doneg_d = doneg_q;
        win_d   = win_q;
        lose_d  = lose_q;
        i_d     = '0;
        j_d     = '0;

        case (state_q)
            ST_ENTRY: begin
                if (bus.sel) begin
                    if (bus.key <= KEY_LAST_LETTER) begin
                        if (len_q != LEN_FULL) begin
                            guess_d[len_q] = bus.key;
                            len_d          = len_q + 3'd1;
                        end
                    end else if (bus.key == KEY_DEL) begin
                        if (len_q != 3'd0) begin
                            guess_d[len_q - 3'd1] = '0;
                            len_d                 = len_q - 3'd1;
                        end
                    end else if (bus.key == KEY_ENT && len_q == LEN_FULL) begin
                        state_d = ST_GREEN;
                    end
                end
            end

            ST_GREEN: begin
                score_d[i_q] = hit ? SC_GRN : SC_GREY;
                used_d[i_q]  = hit;
                doneg_d[i_q] = hit;
                if (i_q == IDX_LAST) begin
                    state_d = ST_YELLOW;
                end else begin
                    i_d = i_q + 3'd1;
                    j_d = i_q + 3'd1;
                end
            end

            ST_YELLOW: begin
                if (hit) begin
                    score_d[i_q] = SC_YEL;
                    used_d[j_q]  = 1'b1;
                    doneg_d[i_q] = 1'b1;
                end
                if (j_q == IDX_LAST) begin
                    if (i_q == IDX_LAST) state_d = ST_REPORT;
                    else                 i_d     = i_q + 3'd1;
                end else begin
                    i_d = i_q;
                    j_d = j_q + 3'd1;
                end
            end

            ST_REPORT: begin
                num_d = num_q + 3'd1;
                if (all_grn) begin
                    win_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (num_q + 3'd1 == NUM_MAX) begin
                    lose_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    guess_d = '0;
                    len_d   = '0;
                    used_d  = '0;
                    doneg_d = '0;
                    state_d = ST_ENTRY;
                end
            end

            ST_DONE: begin
                if (bus.Ack) begin
                    tgt_d   = bus.target;
                    guess_d = '0;
                    score_d = '0;
                    len_d   = '0;
                    num_d   = '0;
                    used_d  = '0;
                    doneg_d = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    state_d = ST_ENTRY;
                end
            end

            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= ST_ENTRY;
            guess_q <= '0;
            tgt_q   <= bus.target;
            score_q <= '0;
            len_q   <= '0;
            num_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            used_q  <= '0;
            doneg_q <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            guess_q <= guess_d;
            tgt_q   <= tgt_d;
            score_q <= score_d;
            len_q   <= len_d;
            num_q   <= num_d;
            i_q     <= i_d;
            j_q     <= j_d;
            used_q  <= used_d;
            doneg_q <= doneg_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    assign bus.guess       = guess_q;
    assign bus.guess_len   = len_q;
    assign bus.guess_num   = num_q;
    assign bus.score       = score_q;
    assign bus.score_valid = (state_q == ST_REPORT);
    assign bus.busy        = (state_q == ST_GREEN) || (state_q == ST_YELLOW) ||
                             (state_q == ST_REPORT);
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;
    assign bus.done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Directed bench for wordle_guess_scorer: entry, scoring, latency, win/lose, reset.
module tb_wordle_guess_scorer
    import wordle_guess_scorer_pkg::*;
;

    logic Clk;
    logic reset;
    int   total;
    int   passed;

    wordle_guess_scorer_if bus();

    wordle_guess_scorer dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic word_t w(input string s);
        word_t r;
        byte   c;
        r = '0;
        for (int k = 0; k < WORD_LEN; k++) begin
            c    = s[k];
            r[k] = letter_t'(c - 8'd65);
        end
        return r;
    endfunction

    task automatic press(input letter_t k);
        bus.sel = 1'b1;
        bus.key = k;
        @(posedge Clk); #1;
        bus.sel = 1'b0;
    endtask

    task automatic type_word(input string s);
        word_t t;
        t = w(s);
        for (int k = 0; k < WORD_LEN; k++) press(t[k]);
    endtask

    // Returns the number of edges after the ENT edge until score_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge Clk); #1;
            n++;
            if (bus.score_valid) break;
        end
    endtask

    task automatic test_reset;
        total++;
        if ({bus.guess_len, bus.guess_num} !== 6'd0)
            $display("FAIL reset_counts: got len=%0d num=%0d want 0 0", bus.guess_len, bus.guess_num);
        else passed++;
        total++;
        if ({bus.score_valid, bus.busy, bus.win, bus.lose, bus.done} !== 5'd0)
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.score_valid, bus.busy, bus.win, bus.lose, bus.done});
        else passed++;
        total++;
        if ({bus.score, bus.guess} !== 35'd0)
            $display("FAIL reset_regs: got score=%b guess=%h want 0", bus.score, bus.guess);
        else passed++;
    endtask

    task automatic test_win;
        int n;
        type_word("CRANE");
        press(KEY_ENT);
        wait_valid(n);
        total++;
        if (n !== 30) $display("FAIL win_latency: got %0d edges want 30", n);
        else passed++;
        total++;
        if (bus.score !== 10'b10_10_10_10_10) $display("FAIL win_score: got %b want 1010101010", bus.score);
        else passed++;
        @(posedge Clk); #1;
        total++;
        if ({bus.win, bus.lose, bus.done, bus.guess_num} !== {3'b101, 3'd1})
            $display("FAIL win_flags: got win=%b lose=%b done=%b num=%0d want 1 0 1 1",
                     bus.win, bus.lose, bus.done, bus.guess_num);
        else passed++;
        press(5'd0);
        total++;
        if (bus.guess_len !== 3'd5 || bus.done !== 1'b1)
            $display("FAIL done_sel_ignored: got len=%0d done=%b want 5 1", bus.guess_len, bus.done);
        else passed++;
        // Ack and sel together: Ack wins, letter dropped
        bus.target = w("APPLE");
        bus.Ack = 1'b1;
        bus.sel = 1'b1;
        bus.key = 5'd0;
        @(posedge Clk); #1;
        bus.Ack = 1'b0;
        bus.sel = 1'b0;
        total++;
        if ({bus.done, bus.win, bus.guess_num, bus.guess_len, bus.score} !== 18'd0)
            $display("FAIL ack_clear: got done=%b win=%b num=%0d len=%0d score=%b want all 0",
                     bus.done, bus.win, bus.guess_num, bus.guess_len, bus.score);
        else passed++;
    endtask

    task automatic test_yellow;
        int n;
        type_word("PAPAL");
        press(KEY_ENT);
        wait_valid(n);
        total++;
        if (bus.score !== 10'b01_00_10_01_01) $display("FAIL dup_score: got %b want 0100100101", bus.score);
        else passed++;
        @(posedge Clk); #1;
        total++;
        if ({bus.guess_num, bus.guess_len, bus.busy, bus.done, bus.win} !== {3'd1, 3'd0, 3'b000})
            $display("FAIL dup_after: got num=%0d len=%0d busy=%b done=%b win=%b want 1 0 0 0 0",
                     bus.guess_num, bus.guess_len, bus.busy, bus.done, bus.win);
        else passed++;
        total++;
        if (bus.score !== 10'b01_00_10_01_01) $display("FAIL score_hold: got %b want 0100100101", bus.score);
        else passed++;
    endtask

    task automatic test_entry_edges;
        press(KEY_DEL);
        total++;
        if (bus.guess_len !== 3'd0) $display("FAIL del_at_0: got len=%0d want 0", bus.guess_len);
        else passed++;
        type_word("ABCDE");
        press(5'd5);
        total++;
        if (bus.guess_len !== 3'd5 || bus.guess !== w("ABCDE"))
            $display("FAIL sixth_letter: got len=%0d guess=%h want 5 %h", bus.guess_len, bus.guess, w("ABCDE"));
        else passed++;
        press(KEY_DEL);
        total++;
        if (bus.guess_len !== 3'd4 || bus.guess !== w("ABCDA"))
            $display("FAIL del_slot: got len=%0d guess=%h want 4 %h", bus.guess_len, bus.guess, w("ABCDA"));
        else passed++;
        press(KEY_ENT);
        total++;
        if (bus.busy !== 1'b0 || bus.guess_len !== 3'd4)
            $display("FAIL ent_short: got busy=%b len=%0d want 0 4", bus.busy, bus.guess_len);
        else passed++;
        press(5'd30);
        total++;
        if (bus.guess_len !== 3'd4 || bus.guess !== w("ABCDA"))
            $display("FAIL key30: got len=%0d guess=%h want 4 %h", bus.guess_len, bus.guess, w("ABCDA"));
        else passed++;
        // Ack outside DONE must not re-latch the target
        bus.target = w("ZZZZZ");
        bus.Ack = 1'b1;
        @(posedge Clk); #1;
        bus.Ack = 1'b0;
        total++;
        if (bus.guess_num !== 3'd1 || bus.guess_len !== 3'd4)
            $display("FAIL ack_entry: got num=%0d len=%0d want 1 4", bus.guess_num, bus.guess_len);
        else passed++;
        repeat (4) press(KEY_DEL);
        total++;
        if (bus.guess_len !== 3'd0 || bus.guess !== '0)
            $display("FAIL del_all: got len=%0d guess=%h want 0 0", bus.guess_len, bus.guess);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int   n;
        logic got;
        logic busy_mid;
        type_word("LEAPP");
        press(KEY_ENT);
        n = 0;
        got = 1'b0;
        busy_mid = 1'b0;
        while (!got && n < 100) begin
            @(posedge Clk); #1;
            n++;
            if (n == 15) busy_mid = bus.busy;
            if (bus.score_valid) got = 1'b1;
            bus.sel = (n == 3) || (n == 20);
            bus.key = (n == 3) ? KEY_ENT : 5'd0;
            bus.Ack = (n == 10) || (n == 25);
        end
        bus.sel = 1'b0;
        bus.Ack = 1'b0;
        total++;
        if (n !== 30) $display("FAIL busy_latency: got %0d edges want 30", n);
        else passed++;
        total++;
        if (busy_mid !== 1'b1) $display("FAIL busy_flag: got %b want 1", busy_mid);
        else passed++;
        total++;
        if (bus.score !== 10'b01_01_01_01_01 || bus.guess !== w("LEAPP"))
            $display("FAIL busy_score: got score=%b guess=%h want 0101010101 %h",
                     bus.score, bus.guess, w("LEAPP"));
        else passed++;
        @(posedge Clk); #1;
        total++;
        if (bus.guess_num !== 3'd2 || bus.guess_len !== 3'd0 || bus.busy !== 1'b0)
            $display("FAIL busy_after: got num=%0d len=%0d busy=%b want 2 0 0",
                     bus.guess_num, bus.guess_len, bus.busy);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int sv_seen;
        bus.target = w("CRANE");
        type_word("ZZZZZ");
        press(KEY_ENT);
        repeat (10) @(posedge Clk);
        #1;
        reset = 1'b1;
        @(posedge Clk); #1;
        total++;
        if ({bus.score_valid, bus.busy, bus.win, bus.lose, bus.done, bus.guess_num, bus.guess_len} !== 11'd0 ||
            {bus.score, bus.guess} !== 35'd0)
            $display("FAIL reset_mid: got sv=%b busy=%b num=%0d len=%0d score=%b guess=%h want all 0",
                     bus.score_valid, bus.busy, bus.guess_num, bus.guess_len, bus.score, bus.guess);
        else passed++;
        reset = 1'b0;
        sv_seen = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (bus.score_valid) sv_seen++;
        end
        total++;
        if (sv_seen !== 0) $display("FAIL reset_no_sv: got %0d pulses want 0", sv_seen);
        else passed++;
    endtask

    task automatic test_lose;
        int n;
        int bad;
        bad = 0;
        for (int g = 0; g < MAX_GUESSES; g++) begin
            type_word("ZZZZZ");
            press(KEY_ENT);
            wait_valid(n);
            if (n != 30 || bus.score != 10'd0) bad++;
            @(posedge Clk); #1;
        end
        total++;
        if (bad !== 0) $display("FAIL lose_guesses: got %0d bad rounds want 0", bad);
        else passed++;
        total++;
        if ({bus.lose, bus.win, bus.done, bus.guess_num} !== {3'b101, 3'd6})
            $display("FAIL lose_flags: got lose=%b win=%b done=%b num=%0d want 1 0 1 6",
                     bus.lose, bus.win, bus.done, bus.guess_num);
        else passed++;
        press(KEY_DEL);
        total++;
        if (bus.guess_len !== 3'd5 || bus.done !== 1'b1)
            $display("FAIL lose_sel_ignored: got len=%0d done=%b want 5 1", bus.guess_len, bus.done);
        else passed++;
        bus.target = w("BRAIN");
        bus.Ack = 1'b1;
        @(posedge Clk); #1;
        bus.Ack = 1'b0;
        total++;
        if ({bus.lose, bus.done, bus.guess_num} !== {2'b00, 3'd0})
            $display("FAIL lose_ack: got lose=%b done=%b num=%0d want 0 0 0", bus.lose, bus.done, bus.guess_num);
        else passed++;
        type_word("BRAIN");
        press(KEY_ENT);
        wait_valid(n);
        total++;
        if (bus.score !== 10'b10_10_10_10_10) $display("FAIL new_target: got %b want 1010101010", bus.score);
        else passed++;
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        Clk         = 1'b0;
        reset       = 1'b1;
        bus.sel     = 1'b0;
        bus.key     = '0;
        bus.Ack     = 1'b0;
        bus.target  = w("CRANE");
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_win();
        test_yellow();
        test_entry_edges();
        test_back_to_back();
        test_reset_mid();
        test_lose();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
